// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: phase/select codes, line levels, parity types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

    // State codes double as the TX mux select. The multiplexer decodes
    // this same enum, so the encoding is defined in one place only.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        SER    = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Payload handshake and mux-control bundle between the byte source and the TX sequencer.
// Latency: n/a (wires only).
// Backpressure: the source holds Data_Valid until busy is low; there is no ready signal.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [2:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    // Byte source / supervisor side
    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, busy
    );

    // Frame sequencer side
    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, busy
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Parity of a DATA_WIDTH-bit word, even or odd selectable.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    // Even parity makes the total count of ones even; odd inverts that.
    assign par_bit_o = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Latency: Data_Valid sampled at edge N gives mux_sel=START and busy=1 from N+1.
// Backpressure: accepts only in IDLE or STOP; Data_Valid elsewhere is ignored, source waits on busy.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    accept;
    logic                    par_calc;

    // Parity type only influences par_bit, so it is folded into the
    // registered par_bit at acceptance rather than kept as its own flop.
    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data_i    (bus.P_DATA),
        .par_typ_i (bus.PAR_TYP),
        .par_bit_o (par_calc)
    );

    // State and busy registers; mux_sel comes straight off state_q so it is glitch-free.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Payload shifter, bit counter and latched frame configuration.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Next-state and datapath: phase sequencing, shift per SER cycle, capture on acceptance.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        accept    = bus.Data_Valid && ((state_q == IDLE) || (state_q == STOP));

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                state_d = SER;
                cnt_d   = '0;
            end
            SER: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides the STOP->IDLE step for back-to-back frames.
        if (accept) begin
            state_d   = START;
            shift_d   = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_bit_d = par_calc;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.mux_sel  = state_q;
    assign bus.busy     = busy_q;
    assign bus.ser_data = shift_q[0];
    assign bus.par_bit  = par_bit_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmitter. It accepts a parallel byte with a valid strobe and latches the data and parity configuration. It then steps the TX output multiplexer through start, serial data, optional parity and stop phases by driving its 3-bit select. It also supplies the serial data bit and the parity bit that the multiplexer forwards to the TX line.

## Interface
- DATA_WIDTH, 8, payload bits per frame (≥2)
- CLK  in  1  TX clock (one bit period per cycle)
- RST  in  1  asynchronous active-low reset
- P_DATA  in  DATA_WIDTH  parallel payload; sampled only on acceptance
- Data_Valid  in  1  payload valid strobe
- PAR_EN  in  1  1 = parity phase inserted; sampled on acceptance
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance
- mux_sel  out  3  phase select: 000 idle, 001 start, 010 ser, 011 parity, 100 stop
- ser_data  out  1  current payload bit, LSB first
- par_bit  out  1  parity bit of the latched payload
- busy  out  1  frame in progress

## Operation
- FSM states IDLE, START, SER, PARITY, STOP.
  - State encoding equals the mux_sel codes.
  - mux_sel is the state register itself: a Moore output with no decode glitches.
- Acceptance occurs when Data_Valid=1 in IDLE, or in STOP (back-to-back).
  - On acceptance, latch P_DATA into the shift register and latch PAR_EN and PAR_TYP.
  - Compute par_bit from the latched data: even → ^data, odd → ~^data. Register par_bit and hold it until the next acceptance.
  - Next state is START.
- Transitions:
  - START → SER, with the bit counter cleared.
  - SER → SER while counter < DATA_WIDTH-1. Each SER cycle shifts the register right and increments the counter.
  - On the last SER cycle, go to PARITY if latched PAR_EN=1, otherwise to STOP.
  - PARITY → STOP.
  - STOP → START if Data_Valid=1, otherwise IDLE.
- ser_data = shift register bit 0.
- Data_Valid in START, SER or PARITY is ignored. No queuing and no error flag; the upstream holds Data_Valid until busy is low.
- busy = 1 in START, SER, PARITY and STOP; 0 in IDLE. busy is registered and derived from the state.
- Counter width is $clog2(DATA_WIDTH). The counter does not wrap inside a frame; its terminal compare is DATA_WIDTH-1.
- P_DATA or PAR_* changes after acceptance do not affect the frame in flight.

## Timing
- Reset (RST=0, asynchronous) forces:
  - state IDLE, so mux_sel=000
  - busy=0, ser_data=0, par_bit=0
  - shift register, counter and latched config cleared
- Reset mid-frame aborts immediately. The line returns to idle-high through the mux select on the same edge-free path. No partial frame resumes after release.
- Latency: Data_Valid is sampled at edge N; mux_sel=001 and busy=1 from N+1.
- Frame length is 1 + DATA_WIDTH + PAR_EN + 1 cycles. That is 11 with parity and 10 without for DATA_WIDTH=8.
- Back-to-back: with Data_Valid=1 during STOP, START follows STOP directly and busy never drops.
- ser_data is valid throughout each SER cycle. Bit k appears in SER cycle k, where k=0 is the LSB.

## Structure
- Shared package uart_tx_pkg holds:
  - the mux_sel/state codes IDLE=3'b000, START=3'b001, SER=3'b010, PARITY=3'b011, STOP=3'b100
  - START_BIT=1'b0 and STOP_BIT=1'b1
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1
- The package is imported by both this block and the TX output multiplexer, so the select encoding has a single source.
- One natural sub-module: uart_parity_calc. It is the combinational reduction of DATA_WIDTH bits plus a type select; this block registers its output.
- Top-level uart_tx instantiates uart_tx_ctrl and the TX mux.

## Test plan
- 0xA5, PAR_EN=1, PAR_TYP=0: mux_sel = 001, 010×8, 011, 100, then 000. ser_data = 1,0,1,0,0,1,0,1. par_bit=0. busy high for 11 cycles.
- 0x01, PAR_EN=1, PAR_TYP=1: par_bit=0. 0x03 odd gives par_bit=1. 0x03 even gives par_bit=0.
- 0xFF, PAR_EN=0: no 011 phase. The last SER cycle is followed by 100. busy high for 10 cycles.
- Back-to-back: 0x5A, then Data_Valid=1 in STOP with 0xC3. The second START follows immediately and busy stays 1 across both frames. The second frame serializes 1,1,0,0,0,0,1,1.
- Data_Valid pulsed with 0x00 during SER of a 0xA5 frame: ignored, and the 0xA5 bit sequence is unaltered. Frame ends in IDLE.
- RST asserted during SER bit 4: outputs go to reset values asynchronously. After release, IDLE holds with mux_sel=000 until a new Data_Valid arrives.
